// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller for I-fetch refills and LSB loads/stores.
// Optional MC_IO_STALL_EN: IO-space stores (addr[17:16]==2'b11) wait while io_buffer_full.
module mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int IF_DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 if_en,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic                 if_done,
    output logic [IF_DATA_W-1:0] if_data,
    input  logic                 lsb_en,
    input  logic                 lsb_wr,
    input  logic [ADDR_W-1:0]    lsb_addr,
    input  logic [2:0]           lsb_len,
    input  logic [31:0]          lsb_wdata,
    output logic                 lsb_done,
    output logic [31:0]          lsb_rdata,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [ADDR_W-1:0]    mem_a,
    output logic                 mem_wr,
    input  logic                 io_buffer_full
);
    typedef enum logic [2:0] {IDLE, IF_RD, LSB_RD, LSB_WR, DONE} state_t;
    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d, cnt_nx;
    logic [2:0]           len_q, len_d;
    logic [31:0]          wdata_q, wdata_d, buf_q, buf_d, buf_nx, lsb_rdata_q, lsb_rdata_d;
    logic [IF_DATA_W-1:0] if_data_q, if_data_d;
    logic [ADDR_W-1:0]    mem_a_q, mem_a_d;
    logic [7:0]           mem_dout_q, mem_dout_d;
    logic                 mem_wr_q, mem_wr_d, if_done_q, if_done_d, lsb_done_q, lsb_done_d;
    logic                 last, io_stall;

`ifdef MC_IO_STALL_EN
    assign io_stall = state_q == LSB_WR && mem_a_q[17:16] == 2'b11 && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign io_stall  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;
        if_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        cnt_nx      = cnt_q + 2'd1;
        last        = {1'b0, cnt_q} == len_q - 3'd1;
        buf_nx      = buf_q;
        buf_nx[{cnt_q, 3'b000} +: 8] = mem_din;
        case (state_q)
            IDLE: begin
                // A flushed LSB request is dropped, but I-fetch may still start this cycle.
                if (lsb_en && !rollback) begin
                    len_d      = lsb_len;
                    wdata_d    = lsb_wdata;
                    mem_a_d    = lsb_addr;
                    cnt_d      = 2'd0;
                    buf_d      = 32'd0;
                    state_d    = lsb_wr ? LSB_WR : LSB_RD;
                    mem_dout_d = lsb_wdata[7:0];
                    mem_wr_d   = lsb_wr;
                end else if (if_en) begin
                    len_d   = 3'd4;
                    mem_a_d = if_addr;
                    cnt_d   = 2'd0;
                    buf_d   = 32'd0;
                    state_d = IF_RD;
                end
            end
            IF_RD, LSB_RD: begin
                if (state_q == LSB_RD && rollback) begin
                    state_d = IDLE;
                end else begin
                    buf_d = buf_nx;
                    if (last) begin
                        state_d     = DONE;
                        if_done_d   = state_q == IF_RD;
                        lsb_done_d  = state_q == LSB_RD;
                        if_data_d   = state_q == IF_RD ? buf_nx[IF_DATA_W-1:0] : if_data_q;
                        lsb_rdata_d = state_q == LSB_RD ? buf_nx : lsb_rdata_q;
                    end else begin
                        cnt_d   = cnt_nx;
                        mem_a_d = mem_a_q + ADDR_W'(1);
                    end
                end
            end
            LSB_WR: begin
                if (!io_stall) begin
                    if (last) begin
                        state_d    = DONE;
                        mem_wr_d   = 1'b0;
                        lsb_done_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_nx;
                        mem_a_d    = mem_a_q + ADDR_W'(1);
                        mem_dout_d = wdata_q[{cnt_nx, 3'b000} +: 8];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            len_q       <= 3'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_data_q   <= '0;
            lsb_rdata_q <= 32'd0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
            if_done_q   <= if_done_d;
            lsb_done_q  <= lsb_done_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q & rdy & ~io_stall;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random checks of mem_ctrl against a byte-array memory model.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback, if_en, lsb_en, lsb_wr, io_buffer_full;
    logic [31:0] if_addr, lsb_addr, lsb_wdata, if_data, lsb_rdata, mem_a;
    logic [2:0]  lsb_len;
    logic [7:0]  mem_din, mem_dout;
    logic        if_done, lsb_done, mem_wr;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  seed;
    logic [7:0]  ram [logic [15:0]];
    logic [7:0]  pre [logic [15:0]];
    logic [7:0]  mdl [logic [15:0]];
    logic [31:0] exp_if, exp_lsb;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return pre.exists(a) ? pre[a] : (a[7:0] * 8'd37 + a[15:8]) ^ seed;
    endfunction

    function automatic logic [7:0] env_rd(input logic [15:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [15:0] a);
        return mdl.exists(a) ? mdl[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input int n);
        logic [31:0] r = 32'd0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mdl_rd(16'(a + 32'(k)));
        return r;
    endfunction

    always @(posedge clk) if (mem_wr) ram[mem_a[15:0]] = mem_dout;
    always @(negedge clk) mem_din <= env_rd(mem_a[15:0]);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_holds();
        chk("if_hold", 64'(if_data), 64'(exp_if));
        chk("lsb_hold", 64'(lsb_rdata), 64'(exp_lsb));
    endtask

    // kind: 0 = I-fetch, 1 = load, 2 = store; rdy is randomly dropped along the way.
    task automatic txn(input int kind, input logic [31:0] addr, input int n, input logic [31:0] wd);
        int          e = 0;
        bit          seen = 1'b0;
        bit          r;
        logic [31:0] exp;
        exp = mdl_load(addr, n);
        if (kind == 0) begin
            if_en   = 1'b1;
            if_addr = addr;
        end else begin
            lsb_en    = 1'b1;
            lsb_wr    = kind == 2;
            lsb_addr  = addr;
            lsb_len   = 3'(n);
            lsb_wdata = wd;
        end
        for (int c = 0; c < 200 && !seen; c++) begin
            r   = $urandom_range(3) != 0;
            rdy = r;
            if (!r && kind == 2) begin
                #1;
                chk("wr_frozen", 64'(mem_wr), 64'd0);
            end
            tick();
            if (r) e++;
            seen = kind == 0 ? if_done : lsb_done;
        end
        rdy    = 1'b1;
        if_en  = 1'b0;
        lsb_en = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(e), 64'(n + 1));
        if (kind == 0) begin
            exp_if = exp;
            chk("if_data", 64'(if_data), 64'(exp));
        end else if (kind == 1) begin
            exp_lsb = exp;
            chk("lsb_rdata", 64'(lsb_rdata), 64'(exp));
        end else begin
            for (int k = 0; k < n; k++) mdl[16'(addr + 32'(k))] = wd[8*k +: 8];
        end
        tick();
        chk("done_clr", 64'({if_done, lsb_done}), 64'd0);
        if (kind == 2)
            for (int k = 0; k < n; k++)
                chk("ram", 64'(env_rd(16'(addr + 32'(k)))), 64'(mdl_rd(16'(addr + 32'(k)))));
        chk_holds();
    endtask

    initial begin
        seed = 8'($urandom);
        pre[16'h0100] = 8'h13;
        pre[16'h0101] = 8'h05;
        pre[16'h0102] = 8'h00;
        pre[16'h0103] = 8'h00;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; if_en = 1'b0; lsb_en = 1'b0; lsb_wr = 1'b0;
        io_buffer_full = 1'b0; if_addr = 32'd0; lsb_addr = 32'd0; lsb_len = 3'd1; lsb_wdata = 32'd0;
        exp_if = 32'd0; exp_lsb = 32'd0;
        ticks(3);
        chk("rst_out", 64'({if_done, lsb_done, mem_wr, mem_dout}), 64'd0);
        chk("rst_a", 64'(mem_a), 64'd0);
        chk_holds();
        rst = 1'b0;
        tick();

        // I-fetch refill: done at E4, no re-accept while en is still high at E5
        if_en = 1'b1; if_addr = 32'h100;
        tick();
        chk("if_a0", 64'(mem_a), 64'h100);
        ticks(3);
        chk("if_early", 64'(if_done), 64'd0);
        tick();
        chk("if_done", 64'(if_done), 64'd1);
        chk("if_word", 64'(if_data), 64'h513);
        tick();
        chk("if_pulse", 64'(if_done), 64'd0);
        chk("if_noreacc", 64'(mem_a), 64'h103);
        if_en = 1'b0; exp_if = 32'h513;
        tick();

        // contention: LSB load wins, I-fetch accepted at E6
        exp_lsb = mdl_load(32'h200, 4);
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = 3'd4;
        if_en = 1'b1; if_addr = 32'h300;
        tick();
        chk("ct_a", 64'(mem_a), 64'h200);
        ticks(4);
        chk("ct_ldone", 64'({lsb_done, if_done}), 64'b10);
        chk("ct_ldata", 64'(lsb_rdata), 64'(exp_lsb));
        lsb_en = 1'b0;
        ticks(2);
        chk("ct_if_acc", 64'(mem_a), 64'h300);
        exp_if = mdl_load(32'h300, 4);
        ticks(4);
        chk("ct_idone", 64'(if_done), 64'd1);
        if_en = 1'b0;
        tick();
        chk_holds();

        // half-word store
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h1002; lsb_len = 3'd2; lsb_wdata = 32'h1234BEEF;
        tick();
        chk("st_b0", 64'({mem_wr, mem_a, mem_dout}), {23'd0, 1'b1, 32'h1002, 8'hEF});
        tick();
        chk("st_b1", 64'({mem_wr, mem_a, mem_dout}), {23'd0, 1'b1, 32'h1003, 8'hBE});
        chk("st_early", 64'(lsb_done), 64'd0);
        tick();
        chk("st_done", 64'({lsb_done, mem_wr}), 64'b10);
        lsb_en = 1'b0; mdl[16'h1002] = 8'hEF; mdl[16'h1003] = 8'hBE;
        tick();
        chk("st_ram", 64'({env_rd(16'h1003), env_rd(16'h1002)}), 64'hBEEF);
        chk_holds();

        // rollback of an in-flight load; pending I-fetch starts right after
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h400; lsb_len = 3'd4;
        if_en = 1'b1; if_addr = 32'h500;
        ticks(3);
        rollback = 1'b1;
        tick();
        chk("rb_nodone", 64'(lsb_done), 64'd0);
        rollback = 1'b0; lsb_en = 1'b0;
        tick();
        chk("rb_if_acc", 64'(mem_a), 64'h500);
        exp_if = mdl_load(32'h500, 4);
        ticks(4);
        chk("rb_idone", 64'({if_done, lsb_done}), 64'b10);
        if_en = 1'b0;
        tick();
        chk_holds();

        // store into IO space with the output FIFO full
        io_buffer_full = 1'b1;
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = 3'd1; lsb_wdata = 32'hA5;
        tick();
`ifdef MC_IO_STALL_EN
        for (int i = 0; i < 3; i++) begin
            chk("io_stall", 64'({mem_wr, lsb_done}), 64'd0);
            if (i < 2) tick();
        end
        io_buffer_full = 1'b0;
        #1;
        chk("io_go", 64'({mem_wr, mem_a}), {31'd0, 1'b1, 32'h30000});
`else
        chk("io_nostall", 64'({mem_wr, mem_a}), {31'd0, 1'b1, 32'h30000});
`endif
        tick();
        chk("io_done", 64'({lsb_done, mem_wr}), 64'b10);
        lsb_en = 1'b0; io_buffer_full = 1'b0; mdl[16'h0000] = 8'hA5;
        tick();
        chk("io_ram", 64'(env_rd(16'h0000)), 64'hA5);

        // synchronous reset in the middle of a refill
        if_en = 1'b1; if_addr = 32'h600;
        ticks(2);
        rst = 1'b1;
        tick();
        chk("mr_out", 64'({if_done, lsb_done, mem_wr, mem_dout}), 64'd0);
        chk("mr_a", 64'(mem_a), 64'd0);
        exp_if = 32'd0; exp_lsb = 32'd0;
        chk_holds();
        rst = 1'b0;
        tick();
        chk("mr_reacc", 64'({if_done, mem_a}), 64'h600);
        exp_if = mdl_load(32'h600, 4);
        ticks(4);
        chk("mr_idone", 64'(if_done), 64'd1);
        if_en = 1'b0;
        tick();
        chk_holds();

        // random traffic, including rdy stalls and 32-bit address wrap
        for (int t = 0; t < 150; t++) begin
            int          kind, n;
            logic [31:0] a;
            kind = $urandom_range(2);
            n    = kind == 0 ? 4 : (1 << $urandom_range(2));
            a    = $urandom_range(9) == 0 ? 32'hFFFFFFFC + 32'($urandom_range(3)) : 32'($urandom_range(16'hFFFF));
            if (kind == 0) a[1:0] = 2'b00;
            txn(kind, a, n, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
